cmd_fetch_unit: RTL and testbench

- Instruction-fetch stage directly upstream of the execution state manager.
- Reads 32-bit command words from memory at the current instruction pointer and holds the word stable on `command` while the state manager executes it.
- Advances the IP, and accepts IP redirects when an executed command writes REG_IP.
- Sequences start/finish handshakes so that each command is presented exactly once.

---
 rtl/cmd_fetch_unit_if.sv | 32 +++
 rtl/cmd_fetch_unit.sv | 167 ++++++++++++++++
 tb/tb_cmd_fetch_unit.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/cmd_fetch_unit_if.sv
//------------------------------------------------------------------------------
// cmd_fetch_unit_if : memory-read bus and command/IP handshake of the fetch unit
// Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface cmd_fetch_unit_if #(
   parameter int ADDR_W = 32
) ();
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_rd;
   logic              mem_ready;
   logic [31:0]       mem_data;
   logic [ADDR_W-1:0] ip;
   logic              ip_load;
   logic [ADDR_W-1:0] ip_in;
   logic [31:0]       command;
   logic              cmd_valid;
   logic              cmd_done;

   modport master (
      output mem_addr, mem_rd, ip, command, cmd_valid,
      input  mem_ready, mem_data, ip_load, ip_in, cmd_done
   );

   modport slave (
      input  mem_addr, mem_rd, ip, command, cmd_valid,
      output mem_ready, mem_data, ip_load, ip_in, cmd_done
   );
endinterface

`default_nettype wire

// File: rtl/cmd_fetch_unit.sv
//------------------------------------------------------------------------------
// cmd_fetch_unit : fetches command words at the IP and presents each one once
// to the state manager. Define CMD_PREFETCH_EN for a one-entry prefetch buffer.
// Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none

module cmd_fetch_unit #(
   parameter int                ADDR_W   = 32,
   parameter logic [ADDR_W-1:0] RESET_IP = '0,
   parameter logic [ADDR_W-1:0] IP_STEP  = ADDR_W'(1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   output logic             busy,
   cmd_fetch_unit_if.master bus
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_HOLD  = 2'd2,
      ST_GAP   = 2'd3
   } state_t;

   state_t            state_q;
   logic [ADDR_W-1:0] ip_q;
   logic [ADDR_W-1:0] fetch_ptr_q;
   logic [ADDR_W-1:0] mem_addr_q;
   logic              mem_rd_q;
   logic [31:0]       command_q;
   logic              cmd_valid_q;
   logic              busy_q;
`ifdef CMD_PREFETCH_EN
   logic [31:0]       pf_data_q;
   logic              pf_valid_q;
`endif

   logic [ADDR_W-1:0] fetch_ptr_inc;
   logic              rd_hit;

   assign fetch_ptr_inc = fetch_ptr_q + IP_STEP;
   assign rd_hit        = mem_rd_q & bus.mem_ready;

   // The state manager also works on the falling edge, so this unit does too.
   always_ff @(negedge clk) begin
      if (!rst) begin
         state_q     <= ST_IDLE;
         ip_q        <= RESET_IP;
         fetch_ptr_q <= RESET_IP;
         mem_addr_q  <= '0;
         mem_rd_q    <= 1'b0;
         command_q   <= '0;
         cmd_valid_q <= 1'b0;
         busy_q      <= 1'b0;
`ifdef CMD_PREFETCH_EN
         pf_data_q   <= '0;
         pf_valid_q  <= 1'b0;
`endif
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (bus.ip_load) begin
                  ip_q        <= bus.ip_in;
                  fetch_ptr_q <= bus.ip_in;
               end
               if (start) begin
                  state_q    <= ST_FETCH;
                  mem_rd_q   <= 1'b1;
                  mem_addr_q <= bus.ip_load ? bus.ip_in : fetch_ptr_q;
                  busy_q     <= 1'b1;
               end
            end

            ST_FETCH: begin
               if (bus.ip_load) begin
                  ip_q        <= bus.ip_in;
                  fetch_ptr_q <= bus.ip_in;
                  mem_addr_q  <= bus.ip_in;
               end else if (rd_hit) begin
                  command_q   <= bus.mem_data;
                  ip_q        <= fetch_ptr_inc;
                  fetch_ptr_q <= fetch_ptr_inc;
                  cmd_valid_q <= 1'b1;
                  mem_rd_q    <= 1'b0;
                  state_q     <= ST_HOLD;
               end
            end

            ST_HOLD: begin
               // A redirect lands before cmd_done so the next fetch uses ip_in.
               if (bus.ip_load) begin
                  ip_q        <= bus.ip_in;
                  fetch_ptr_q <= bus.ip_in;
`ifdef CMD_PREFETCH_EN
                  pf_valid_q  <= 1'b0;
                  mem_rd_q    <= 1'b0;
`endif
               end
`ifdef CMD_PREFETCH_EN
               else if (rd_hit) begin
                  pf_data_q   <= bus.mem_data;
                  pf_valid_q  <= 1'b1;
                  fetch_ptr_q <= fetch_ptr_inc;
                  mem_rd_q    <= 1'b0;
               end else if (!pf_valid_q && !mem_rd_q) begin
                  mem_rd_q    <= 1'b1;
                  mem_addr_q  <= fetch_ptr_q;
               end
`endif
               if (bus.cmd_done) begin
                  cmd_valid_q <= 1'b0;
                  state_q     <= ST_GAP;
               end
            end

            ST_GAP: begin
               if (bus.ip_load) begin
                  ip_q        <= bus.ip_in;
                  fetch_ptr_q <= bus.ip_in;
                  mem_addr_q  <= bus.ip_in;
                  mem_rd_q    <= 1'b1;
                  state_q     <= ST_FETCH;
`ifdef CMD_PREFETCH_EN
                  pf_valid_q  <= 1'b0;
`endif
               end
`ifdef CMD_PREFETCH_EN
               // A prefetch read completing here goes straight to command.
               else if (rd_hit) begin
                  command_q   <= bus.mem_data;
                  ip_q        <= fetch_ptr_inc;
                  fetch_ptr_q <= fetch_ptr_inc;
                  cmd_valid_q <= 1'b1;
                  mem_rd_q    <= 1'b0;
                  state_q     <= ST_HOLD;
               end else if (pf_valid_q) begin
                  command_q   <= pf_data_q;
                  ip_q        <= fetch_ptr_q;
                  pf_valid_q  <= 1'b0;
                  cmd_valid_q <= 1'b1;
                  state_q     <= ST_HOLD;
               end
`endif
               else begin
                  mem_rd_q    <= 1'b1;
                  mem_addr_q  <= fetch_ptr_q;
                  state_q     <= ST_FETCH;
               end
            end

            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_rd    = mem_rd_q;
   assign bus.ip        = ip_q;
   assign bus.command   = command_q;
   assign bus.cmd_valid = cmd_valid_q;
   assign busy          = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_cmd_fetch_unit.sv
//------------------------------------------------------------------------------
// tb_cmd_fetch_unit : directed vectors for cmd_fetch_unit with a wait-state
// memory model. Prefetch vectors are used when CMD_PREFETCH_EN is defined.
// Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_cmd_fetch_unit;

   logic clk = 1'b1;
   logic rst;
   logic start;
   logic start2;
   logic busy;
   logic busy2;

   int n_checks = 0;
   int n_fail   = 0;

   int wait_cfg   = 0;
   int wcnt       = 0;
   bit addr2_seen = 1'b0;

   cmd_fetch_unit_if #(.ADDR_W(32)) bus  ();
   cmd_fetch_unit_if #(.ADDR_W(32)) bus2 ();

   cmd_fetch_unit #(.ADDR_W(32)) u_dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .busy  (busy),
      .bus   (bus)
   );

   cmd_fetch_unit #(.ADDR_W(32), .RESET_IP(32'hFFFF_FFFF)) u_dut_wrap (
      .clk   (clk),
      .rst   (rst),
      .start (start2),
      .busy  (busy2),
      .bus   (bus2)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      case (a)
         32'd0:   return 32'h0000_1234;
         32'd1:   return 32'hAAAA_0001;
         default: return 32'hD000_0000 | a;
      endcase
   endfunction

   // Memory answers wait_cfg posedges after a read is seen, away from the DUT edge.
   always @(posedge clk) begin
      if (bus.mem_rd) begin
         if (bus.mem_addr == 32'd2) addr2_seen = 1'b1;
         if (wcnt >= wait_cfg) begin
            bus.mem_ready = 1'b1;
            bus.mem_data  = mem_word(bus.mem_addr);
            wcnt          = 0;
         end else begin
            bus.mem_ready = 1'b0;
            wcnt          = wcnt + 1;
         end
      end else begin
         bus.mem_ready = 1'b0;
         wcnt          = 0;
      end
   end

   always @(posedge clk) begin
      bus2.mem_ready = bus2.mem_rd;
      bus2.mem_data  = 32'h5A5A_0000;
   end

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

`ifdef CMD_PREFETCH_EN
   logic [31:0] pf_exp [4] = '{32'h0000_1234, 32'hAAAA_0001, 32'hD000_0002, 32'hD000_0003};
`endif

   initial begin
      rst = 1'b0;
      start = 1'b0;
      start2 = 1'b0;
      bus.ip_load = 1'b0;
      bus.ip_in = '0;
      bus.cmd_done = 1'b0;
      bus2.ip_load = 1'b0;
      bus2.ip_in = '0;
      bus2.cmd_done = 1'b0;

      repeat (3) @(posedge clk);
      check_val("rst_ip", bus.ip, 32'h0);
      check_val("rst_command", bus.command, 32'h0);
      check_val("rst_cmd_valid", bus.cmd_valid, 1'b0);
      check_val("rst_mem_rd", bus.mem_rd, 1'b0);
      check_val("rst_mem_addr", bus.mem_addr, 32'h0);
      check_val("rst_busy", busy, 1'b0);
      check_val("rst_wrap_ip", bus2.ip, 32'hFFFF_FFFF);
      check_val("rst_wrap_busy", busy2, 1'b0);
      rst = 1'b1;

      @(posedge clk);
      start = 1'b1;
      start2 = 1'b1;

      @(posedge clk);
      check_val("f1_mem_rd", bus.mem_rd, 1'b1);
      check_val("f1_mem_addr", bus.mem_addr, 32'h0);
      check_val("f1_busy", busy, 1'b1);
      check_val("f1_valid_low", bus.cmd_valid, 1'b0);
      check_val("wrap_mem_addr", bus2.mem_addr, 32'hFFFF_FFFF);
      start = 1'b0;
      start2 = 1'b0;

      @(posedge clk);
      check_val("f1_command", bus.command, 32'h0000_1234);
      check_val("f1_cmd_valid", bus.cmd_valid, 1'b1);
      check_val("f1_ip", bus.ip, 32'h1);
      check_val("f1_mem_rd_off", bus.mem_rd, 1'b0);
      check_val("wrap_ip", bus2.ip, 32'h0);
      check_val("wrap_command", bus2.command, 32'h5A5A_0000);
      check_val("wrap_cmd_valid", bus2.cmd_valid, 1'b1);

`ifndef CMD_PREFETCH_EN
      // Second command with two wait states.
      wait_cfg = 2;
      bus.cmd_done = 1'b1;
      @(posedge clk);
      bus.cmd_done = 1'b0;
      check_val("gap_valid", bus.cmd_valid, 1'b0);
      check_val("gap_busy", busy, 1'b1);
      @(posedge clk);
      check_val("f2_mem_addr", bus.mem_addr, 32'h1);
      check_val("f2_mem_rd", bus.mem_rd, 1'b1);
      repeat (2) @(posedge clk);
      check_val("f2_wait_valid", bus.cmd_valid, 1'b0);
      @(posedge clk);
      check_val("f2_command", bus.command, 32'hAAAA_0001);
      check_val("f2_ip", bus.ip, 32'h2);
      check_val("f2_cmd_valid", bus.cmd_valid, 1'b1);

      // Redirect coinciding with cmd_done.
      wait_cfg = 0;
      bus.cmd_done = 1'b1;
      bus.ip_load = 1'b1;
      bus.ip_in = 32'h40;
      @(posedge clk);
      bus.cmd_done = 1'b0;
      bus.ip_load = 1'b0;
      check_val("rd1_ip", bus.ip, 32'h40);
      check_val("rd1_valid", bus.cmd_valid, 1'b0);
      @(posedge clk);
      check_val("rd1_mem_addr", bus.mem_addr, 32'h40);
      @(posedge clk);
      check_val("rd1_command", bus.command, 32'hD000_0040);
      check_val("rd1_ip_after", bus.ip, 32'h41);
      check_val("addr2_never_read", addr2_seen, 1'b0);

      // Redirect on the same edge as mem_ready in FETCH.
      bus.cmd_done = 1'b1;
      @(posedge clk);
      bus.cmd_done = 1'b0;
      @(posedge clk);
      check_val("rd2_fetch_addr", bus.mem_addr, 32'h41);
      bus.ip_load = 1'b1;
      bus.ip_in = 32'h80;
      @(posedge clk);
      bus.ip_load = 1'b0;
      check_val("rd2_valid", bus.cmd_valid, 1'b0);
      check_val("rd2_mem_addr", bus.mem_addr, 32'h80);
      check_val("rd2_mem_rd", bus.mem_rd, 1'b1);
      check_val("rd2_ip", bus.ip, 32'h80);
      check_val("rd2_cmd_held", bus.command, 32'hD000_0040);
      @(posedge clk);
      check_val("rd2_command", bus.command, 32'hD000_0080);
      check_val("rd2_ip_after", bus.ip, 32'h81);

      // Reset in the middle of a fetch.
      wait_cfg = 5;
      bus.cmd_done = 1'b1;
      @(posedge clk);
      bus.cmd_done = 1'b0;
      @(posedge clk);
      check_val("mid_mem_rd", bus.mem_rd, 1'b1);
      rst = 1'b0;
      @(posedge clk);
      check_val("mid_rst_ip", bus.ip, 32'h0);
      check_val("mid_rst_mem_addr", bus.mem_addr, 32'h0);
      check_val("mid_rst_mem_rd", bus.mem_rd, 1'b0);
      check_val("mid_rst_command", bus.command, 32'h0);
      check_val("mid_rst_valid", bus.cmd_valid, 1'b0);
      check_val("mid_rst_busy", busy, 1'b0);
      rst = 1'b1;
      wait_cfg = 0;
      start = 1'b1;
      @(posedge clk);
      start = 1'b0;
      @(posedge clk);
      check_val("re_command", bus.command, 32'h0000_1234);
      check_val("re_ip", bus.ip, 32'h1);
`else
      // Back-to-back commands with cmd_done in every HOLD.
      bus.cmd_done = 1'b1;
      for (int k = 1; k < 4; k++) begin
         @(posedge clk);
         check_val("pf_gap_valid", bus.cmd_valid, 1'b0);
         @(posedge clk);
         check_val("pf_command", bus.command, pf_exp[k]);
         check_val("pf_ip", bus.ip, 64'(k + 1));
      end
      bus.cmd_done = 1'b0;
      repeat (2) @(posedge clk);
      check_val("pf_ip_not_adv", bus.ip, 32'h4);
      check_val("pf_full_no_rd", bus.mem_rd, 1'b0);
      check_val("pf_cmd_held", bus.command, 32'hD000_0003);
      bus.ip_load = 1'b1;
      bus.ip_in = 32'h10;
      @(posedge clk);
      bus.ip_load = 1'b0;
      bus.cmd_done = 1'b1;
      check_val("pf_redir_ip", bus.ip, 32'h10);
      @(posedge clk);
      bus.cmd_done = 1'b0;
      check_val("pf_redir_gap", bus.cmd_valid, 1'b0);
      @(posedge clk);
      check_val("pf_redir_cmd", bus.command, 32'hD000_0010);
      check_val("pf_redir_ip2", bus.ip, 32'h11);
      repeat (2) @(posedge clk);
      check_val("pf_buf_ip_held", bus.ip, 32'h11);
      bus.cmd_done = 1'b1;
      @(posedge clk);
      bus.cmd_done = 1'b0;
      check_val("pf_buf_no_rd", bus.mem_rd, 1'b0);
      @(posedge clk);
      check_val("pf_buf_cmd", bus.command, 32'hD000_0011);
      check_val("pf_buf_ip", bus.ip, 32'h12);
      check_val("pf_buf_valid", bus.cmd_valid, 1'b1);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
